turf_scanner: RTL and testbench

Territory tally engine for the TurfWars game. When the round ends, it sweeps the 160x120 trail RAM and counts how many pixels each player's colour owns. It then names the winner, producing the `p1_count`..`p4_count` and `winner` values consumed by the top level, the hex displays and the DRAW_WINNER path. It is the reading end of the trail RAM, which the drawing datapath writes during play.

---
 rtl/turf_pkg.sv | 37 +++
 rtl/turf_argmax4.sv | 39 +++
 rtl/turf_scanner.sv | 167 ++++++++++++++++
 tb/tb_turf_scanner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/turf_pkg.sv
// Shared TurfWars constants: screen geometry, trail colour codes and the scanner FSM states.
package turf_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;
  localparam int CNT_W    = 15;

  localparam logic [2:0] COL_P1    = 3'b001;
  localparam logic [2:0] COL_P2    = 3'b010;
  localparam logic [2:0] COL_P3    = 3'b100;
  localparam logic [2:0] COL_P4    = 3'b110;
  localparam logic [2:0] COL_BG    = 3'b000;
  localparam logic [2:0] COL_TIMER = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } turf_state_t;

  // Maps a trail colour to {owned, player index}; unowned codes return 3'b000.
  function automatic logic [2:0] col_player(input logic [2:0] col);
    case (col)
      COL_P1:    col_player = 3'b100;
      COL_P2:    col_player = 3'b101;
      COL_P3:    col_player = 3'b110;
      COL_P4:    col_player = 3'b111;
      COL_BG:    col_player = 3'b000;
      COL_TIMER: col_player = 3'b000;
      default:   col_player = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/turf_argmax4.sv
// Combinational argmax over four player counts; ties resolve to the lower index.
// Optional tie flag when TURF_SCANNER_TIE_EN is defined.
module turf_argmax4
  import turf_pkg::*;
(
  input  logic [CNT_W-1:0] c0,
  input  logic [CNT_W-1:0] c1,
  input  logic [CNT_W-1:0] c2,
  input  logic [CNT_W-1:0] c3,
`ifdef TURF_SCANNER_TIE_EN
  output logic             tie,
`endif
  output logic [1:0]       winner
);

  logic             gt1_s, gt2_s, gt3_s;
  logic [CNT_W-1:0] m01_s, m012_s, max_s;
  logic [1:0]       i01_s, i012_s;

  // Strict greater-than chain keeps the earlier player on equality.
  assign gt1_s  = (c1 > c0);
  assign m01_s  = gt1_s ? c1 : c0;
  assign i01_s  = gt1_s ? 2'd1 : 2'd0;
  assign gt2_s  = (c2 > m01_s);
  assign m012_s = gt2_s ? c2 : m01_s;
  assign i012_s = gt2_s ? 2'd2 : i01_s;
  assign gt3_s  = (c3 > m012_s);
  assign max_s  = gt3_s ? c3 : m012_s;
  assign winner = gt3_s ? 2'd3 : i012_s;

`ifdef TURF_SCANNER_TIE_EN
  logic [2:0] eq_cnt_s;

  assign eq_cnt_s = {2'b00, (c0 == max_s)} + {2'b00, (c1 == max_s)}
                  + {2'b00, (c2 == max_s)} + {2'b00, (c3 == max_s)};
  assign tie      = (max_s != {CNT_W{1'b0}}) && (eq_cnt_s > 3'd1);
`endif

endmodule

// File: rtl/turf_scanner.sv
// End-of-round territory tally: sweeps the 160x120 trail RAM, counts pixels per player, names the winner.
// Optional `tie` output when TURF_SCANNER_TIE_EN is defined.
module turf_scanner
  import turf_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [2:0]        ram_q,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  p1_count,
  output logic [CNT_W-1:0]  p2_count,
  output logic [CNT_W-1:0]  p3_count,
  output logic [CNT_W-1:0]  p4_count,
`ifdef TURF_SCANNER_TIE_EN
  output logic              tie,
`endif
  output logic [1:0]        winner
);

  turf_state_t           state_r;
  logic [7:0]            x_r;
  logic [6:0]            y_r;
  logic [1:0]            drain_r;
  logic [RD_LATENCY-1:0] vld_r;
  logic                  scan_s;
  logic                  tag_s;
  logic                  hit_s;
  logic [1:0]            pidx_s;
  logic [1:0]            win_s;
`ifdef TURF_SCANNER_TIE_EN
  logic                  tie_s;
`endif

  assign rd_address      = {x_r, y_r};
  assign scan_s          = (state_r == ST_SCAN);
  assign tag_s           = vld_r[RD_LATENCY-1];
  assign {hit_s, pidx_s} = tag_s ? col_player(ram_q) : 3'b000;

  turf_argmax4 u_argmax (
    .c0     (p1_count),
    .c1     (p2_count),
    .c2     (p3_count),
    .c3     (p4_count),
`ifdef TURF_SCANNER_TIE_EN
    .tie    (tie_s),
`endif
    .winner (win_s)
  );

  // Valid-delay line: tags the ram_q that belongs to each issued address.
  if (RD_LATENCY == 1) begin : g_vld1
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        vld_r <= 1'b0;
      end else begin
        vld_r <= scan_s;
      end
    end
  end else begin : g_vldn
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        vld_r <= '0;
      end else begin
        vld_r <= {vld_r[RD_LATENCY-2:0], scan_s};
      end
    end
  end

  // Scan FSM with registered port outputs and the per-player tallies.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      x_r      <= 8'd0;
      y_r      <= 7'd0;
      drain_r  <= 2'd0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      p1_count <= '0;
      p2_count <= '0;
      p3_count <= '0;
      p4_count <= '0;
      winner   <= 2'd0;
`ifdef TURF_SCANNER_TIE_EN
      tie      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r  <= ST_SCAN;
            x_r      <= 8'd0;
            y_r      <= 7'd0;
            rd_en    <= 1'b1;
            busy     <= 1'b1;
            p1_count <= '0;
            p2_count <= '0;
            p3_count <= '0;
            p4_count <= '0;
          end
        end
        ST_SCAN: begin
          if (y_r == 7'(SCREEN_H - 1)) begin
            y_r <= 7'd0;
            if (x_r == 8'(SCREEN_W - 1)) begin
              x_r     <= 8'd0;
              drain_r <= 2'd0;
              state_r <= ST_DRAIN;
            end else begin
              x_r <= x_r + 8'd1;
            end
          end else begin
            y_r <= y_r + 7'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_r == 2'(RD_LATENCY - 1)) begin
            rd_en   <= 1'b0;
            state_r <= ST_DECIDE;
          end else begin
            drain_r <= drain_r + 2'd1;
          end
        end
        ST_DECIDE: begin
          winner  <= win_s;
`ifdef TURF_SCANNER_TIE_EN
          tie     <= tie_s;
`endif
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          rd_en   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          x_r     <= 8'd0;
          y_r     <= 7'd0;
          state_r <= ST_IDLE;
        end
      endcase

      // Tagged samples only arrive during SCAN/DRAIN, never alongside the IDLE clear.
      if (hit_s) begin
        case (pidx_s)
          2'd0:    p1_count <= p1_count + 15'd1;
          2'd1:    p2_count <= p2_count + 15'd1;
          2'd2:    p3_count <= p3_count + 15'd1;
          2'd3:    p4_count <= p4_count + 15'd1;
          default: p1_count <= p1_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turf_scanner.sv
// Bench for turf_scanner: RD_LATENCY=1 and RD_LATENCY=3 instances share one modelled trail RAM
// and are checked against a pixel-counting reference model.
module tb_turf_scanner;
  import turf_pkg::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        resetn;
  logic        start;
  logic        rd_en_a, rd_en_b, busy_a, busy_b, done_a, done_b;
  logic [14:0] addr_a, addr_b;
  logic [2:0]  q_a, q_b;
  logic [14:0] cnt_a [4];
  logic [14:0] cnt_b [4];
  logic [1:0]  win_a, win_b;
`ifdef TURF_SCANNER_TIE_EN
  logic        tie_a, tie_b;
`endif

  turf_scanner #(.RD_LATENCY(1)) dut_a (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .rd_en(rd_en_a), .rd_address(addr_a),
    .ram_q(q_a), .busy(busy_a), .done(done_a), .p1_count(cnt_a[0]), .p2_count(cnt_a[1]),
    .p3_count(cnt_a[2]), .p4_count(cnt_a[3]),
`ifdef TURF_SCANNER_TIE_EN
    .tie(tie_a),
`endif
    .winner(win_a));

  turf_scanner #(.RD_LATENCY(3)) dut_b (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .rd_en(rd_en_b), .rd_address(addr_b),
    .ram_q(q_b), .busy(busy_b), .done(done_b), .p1_count(cnt_b[0]), .p2_count(cnt_b[1]),
    .p3_count(cnt_b[2]), .p4_count(cnt_b[3]),
`ifdef TURF_SCANNER_TIE_EN
    .tie(tie_b),
`endif
    .winner(win_b));

  // Trail RAM model with per-instance read pipelines of depth 1 and 3.
  logic [2:0] mem [32768];
  logic [2:0] pipe_a;
  logic [2:0] pipe_b [3];
  assign q_a = pipe_a;
  assign q_b = pipe_b[2];

  always @(posedge clk) begin
    pipe_a    <= mem[addr_a];
    pipe_b[0] <= mem[addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  // Address-port monitor: legality, number of rd_en cycles and distinct addresses seen.
  bit seen_a [32768];
  bit seen_b [32768];
  int issued_a, issued_b, distinct_a, distinct_b, bad_a, bad_b;

  always @(posedge clk) begin
    if (resetn) begin
      if (rd_en_a) begin
        issued_a++;
        if (addr_a[6:0] >= 7'd120 || addr_a[14:7] >= 8'd160) bad_a++;
        if (!seen_a[addr_a]) begin seen_a[addr_a] = 1'b1; distinct_a++; end
      end else if (addr_a != 15'd0) bad_a++;
      if (rd_en_b) begin
        issued_b++;
        if (addr_b[6:0] >= 7'd120 || addr_b[14:7] >= 8'd160) bad_b++;
        if (!seen_b[addr_b]) begin seen_b[addr_b] = 1'b1; distinct_b++; end
      end else if (addr_b != 15'd0) bad_b++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  int exp_cnt [4];
  int exp_win;
  bit exp_tie;

  // Reference: count owned pixels over the visible screen, then strict argmax.
  task automatic compute_expected();
    logic [2:0] c;
    int best;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) begin
        c = mem[x * 128 + y];
        if (c == 3'b001) exp_cnt[0]++;
        else if (c == 3'b010) exp_cnt[1]++;
        else if (c == 3'b100) exp_cnt[2]++;
        else if (c == 3'b110) exp_cnt[3]++;
      end
    best = 0;
    for (int i = 1; i < 4; i++) if (exp_cnt[i] > exp_cnt[best]) best = i;
    exp_win = best;
    exp_tie = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i != best && exp_cnt[i] == exp_cnt[best] && exp_cnt[best] != 0) exp_tie = 1'b1;
  endtask

  task automatic fill_offscreen_junk();
    for (int a = 0; a < 32768; a++)
      if ((a % 128) >= 120 || (a / 128) >= 160) mem[a] = 3'($urandom);
  endtask

  task automatic clear_monitors();
    for (int a = 0; a < 32768; a++) begin seen_a[a] = 1'b0; seen_b[a] = 1'b0; end
    issued_a = 0; issued_b = 0; distinct_a = 0; distinct_b = 0; bad_a = 0; bad_b = 0;
  endtask

  task automatic check_reset_state(input string name);
    check_val({name, "_rd_en"}, 32'(rd_en_a | rd_en_b), 32'd0);
    check_val({name, "_addr"}, 32'(addr_a | addr_b), 32'd0);
    check_val({name, "_busy"}, 32'(busy_a | busy_b), 32'd0);
    check_val({name, "_done"}, 32'(done_a | done_b), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_a_p%0d", name, i + 1), 32'(cnt_a[i]), 32'd0);
      check_val($sformatf("%s_b_p%0d", name, i + 1), 32'(cnt_b[i]), 32'd0);
    end
    check_val({name, "_win"}, 32'(win_a | win_b), 32'd0);
  endtask

  // One scan from a start pulse; optional mid-scan start at E100 and start while done is high.
  task automatic run_scan(input string name, input bit extra_starts);
    int dka, dkb, npa, npb;
    compute_expected();
    clear_monitors();
    dka = -1; dkb = -1; npa = 0; npb = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_val({name, "_first_busy"}, 32'(busy_a & busy_b), 32'd1);
    check_val({name, "_first_rd_en"}, 32'(rd_en_a & rd_en_b), 32'd1);
    check_val({name, "_first_addr"}, 32'(addr_a | addr_b), 32'd0);
    for (int k = 1; k <= 19400; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done_a) begin
        npa++;
        if (dka < 0) begin
          dka = k;
          if (extra_starts) start = 1'b1;
        end
      end
      if (done_b) begin npb++; if (dkb < 0) dkb = k; end
      if (extra_starts && k == 99) start = 1'b1;
    end
    check_val({name, "_done_edge_l1"}, 32'(dka), 32'd19202);
    check_val({name, "_done_edge_l3"}, 32'(dkb), 32'd19204);
    check_val({name, "_done_pulses_a"}, 32'(npa), 32'd1);
    check_val({name, "_done_pulses_b"}, 32'(npb), 32'd1);
    check_val({name, "_idle_busy"}, 32'(busy_a | busy_b), 32'd0);
    check_val({name, "_issued_a"}, 32'(issued_a), 32'd19201);
    check_val({name, "_issued_b"}, 32'(issued_b), 32'd19203);
    check_val({name, "_distinct_a"}, 32'(distinct_a), 32'd19200);
    check_val({name, "_distinct_b"}, 32'(distinct_b), 32'd19200);
    check_val({name, "_bad_addr"}, 32'(bad_a + bad_b), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_a_p%0d", name, i + 1), 32'(cnt_a[i]), 32'(exp_cnt[i]));
      check_val($sformatf("%s_b_p%0d", name, i + 1), 32'(cnt_b[i]), 32'(exp_cnt[i]));
    end
    check_val({name, "_win_a"}, 32'(win_a), 32'(exp_win));
    check_val({name, "_win_b"}, 32'(win_b), 32'(exp_win));
`ifdef TURF_SCANNER_TIE_EN
    check_val({name, "_tie_a"}, 32'(tie_a), 32'(exp_tie));
    check_val({name, "_tie_b"}, 32'(tie_b), 32'(exp_tie));
`endif
  endtask

  task automatic place(input logic [2:0] col, input int n);
    int x, y, placed;
    placed = 0;
    while (placed < n) begin
      x = $urandom_range(0, 159);
      y = $urandom_range(0, 118);
      if (mem[x * 128 + y] == 3'b000) begin mem[x * 128 + y] = col; placed++; end
    end
  endtask

  initial begin
    logic [2:0] c;
    for (int a = 0; a < 32768; a++) mem[a] = 3'b000;
    pipe_a = 3'b000;
    for (int i = 0; i < 3; i++) pipe_b[i] = 3'b000;
    start  = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);

    // All-zero screen, with ignored starts mid-scan and during done.
    run_scan("zero", 1'b1);
    check_val("zero_p2_const", 32'(cnt_a[1]), 32'd0);

    // Columns 0..39 owned by player 2.
    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 120; y++) mem[x * 128 + y] = 3'b010;
    fill_offscreen_junk();
    run_scan("cols", 1'b0);
    check_val("cols_p2_const", 32'(cnt_a[1]), 32'd4800);
    check_val("cols_win_const", 32'(win_a), 32'd1);

    // 100/200/300/300 with a timer-bar row at y=119.
    for (int a = 0; a < 32768; a++) mem[a] = 3'b000;
    for (int x = 0; x < 160; x++) mem[x * 128 + 119] = 3'b111;
    place(3'b001, 100); place(3'b010, 200); place(3'b100, 300); place(3'b110, 300);
    fill_offscreen_junk();
    run_scan("tie", 1'b0);
    check_val("tie_p3_const", 32'(cnt_a[2]), 32'd300);
    check_val("tie_win_const", 32'(win_a), 32'd2);

    // Random non-p4 codes with one p4 pixel at the last address and one just past it.
    for (int a = 0; a < 32768; a++) begin
      c = 3'($urandom);
      if (c == 3'b110) c = 3'b011;
      mem[a] = c;
    end
    fill_offscreen_junk();
    mem[{8'd159, 7'd119}] = 3'b110;
    mem[{8'd159, 7'd120}] = 3'b110;
    run_scan("edge", 1'b0);
    check_val("edge_p4_const", 32'(cnt_a[3]), 32'd1);

    // Reset at E5000 mid-scan, then a clean random scan.
    for (int a = 0; a < 32768; a++) mem[a] = 3'($urandom);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4999) @(posedge clk);
    #1 resetn = 1'b0;
    #1 check_reset_state("midreset");
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);
    run_scan("rand", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
